// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer and the control unit it
// feeds: FSM encoding, the 2-bit execute-step encodings, default widths and
// the opcode constants the control unit decodes from instruction[15:12].
package instr_seq_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F0    = 3'd1,
        S_F1    = 3'd2,
        S_EXEC  = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } seq_state_t;

    // Execute-step encodings presented on current_state
    localparam logic [1:0] STEP_0 = 2'b00;
    localparam logic [1:0] STEP_1 = 2'b01;
    localparam logic [1:0] STEP_2 = 2'b10;
    localparam logic [1:0] STEP_3 = 2'b11;

    // Opcodes carried in instruction[15:12]
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the sequencer, its instruction memory and the control unit.
//   imem_addr     : fetch address (= pc)
//   imem_data     : synchronous memory read data, 1-cycle latency
//   instruction   : instruction register presented to the control unit
//   current_state : execute step counter presented to the control unit
//   clear_counter : retire request from the control unit
// master = sequencer side, slave = memory / control unit side.
interface instr_sequencer_if import instr_seq_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instruction;
    logic [1:0]         current_state;
    logic               clear_counter;

    modport master (
        output imem_addr, instruction, current_state,
        input  imem_data, clear_counter
    );

    modport slave (
        input  imem_addr, instruction, current_state,
        output imem_data, clear_counter
    );
endinterface

// File: rtl/seq_step_counter.sv
// 2-bit execute step counter.
//   clock, resetn : clock, asynchronous active-low reset
//   inc           : advance one step (wraps 11 -> 00)
//   clr           : return to step 00; wins over inc
//   step          : current step
module seq_step_counter import instr_seq_pkg::*; (
    input  logic       clock,
    input  logic       resetn,
    input  logic       inc,
    input  logic       clr,
    output logic [1:0] step
);
    logic [1:0] r_step;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)  r_step <= STEP_0;
        else if (clr) r_step <= STEP_0;
        else if (inc) r_step <= r_step + 2'd1;
    end

    assign step = r_step;
endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches prog_len instructions from a synchronous
// instruction memory and steps each through a 1-4 cycle execute phase.
//   clock, resetn  : clock, asynchronous active-low reset
//   run            : level; 0 stops at the next instruction boundary
//   step_mode      : pause after every retired instruction
//   step_req       : pulse releasing one instruction from PAUSE
//   prog_len       : program length, latched when leaving IDLE
//   busy           : 1 in every state except IDLE
//   done           : one-cycle pulse on program completion
//   instr_count    : retired instruction count
//   bus            : memory fetch + control unit signals (master side)
module instr_sequencer import instr_seq_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic [ADDR_W-1:0] prog_len,
    output logic              busy,
    output logic              done,
    output logic [7:0]        instr_count,
    instr_sequencer_if.master bus
);
    seq_state_t         r_state, w_next;
    logic [ADDR_W-1:0]  r_pc, r_len;
    logic [INSTR_W-1:0] r_instr;
    logic [7:0]         r_count;
    logic [1:0]         w_step;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_retire;
    logic               w_start;

    assign w_pc_inc = r_pc + 1'b1;
    // Step 11 retires even without clear_counter
    assign w_retire = (r_state == S_EXEC) && (bus.clear_counter || w_step == STEP_3);
    assign w_start  = (r_state == S_IDLE) && run && (prog_len != '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_F0;
            S_F0:    w_next = S_F1;
            S_F1:    w_next = S_EXEC;
            S_EXEC: begin
                // run/step_mode only matter here, at the retire boundary
                if (w_retire) begin
                    if (w_pc_inc == r_len) w_next = S_DONE;
                    else if (!run)         w_next = S_IDLE;
                    else if (step_mode)    w_next = S_PAUSE;
                    else                   w_next = S_F0;
                end
            end
            S_PAUSE: begin
                if (!run)          w_next = S_IDLE;
                else if (step_req) w_next = S_F0;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc    <= '0;
            r_len   <= '0;
            r_instr <= '0;
            r_count <= '0;
        end else begin
            if (w_start) begin
                r_pc    <= '0;
                r_count <= '0;
                r_len   <= prog_len;
            end
            // Memory data for the F0 address arrives during F1
            if (r_state == S_F1) r_instr <= bus.imem_data;
            if (w_retire) begin
                r_pc    <= w_pc_inc;
                r_count <= r_count + 8'd1;
            end
        end
    end

    // Held at 00 outside EXEC and cleared on every retire so each
    // instruction enters EXEC at step 00
    seq_step_counter u_step (
        .clock  (clock),
        .resetn (resetn),
        .inc    ((r_state == S_EXEC) && !w_retire),
        .clr    (w_retire || (r_state != S_EXEC)),
        .step   (w_step)
    );

    assign bus.imem_addr     = r_pc;
    assign bus.instruction   = r_instr;
    assign bus.current_state = w_step;
    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign instr_count       = r_count;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer. Each program run pushes its expected outcome
// (retired count, final instruction, done pulses, busy cycles, trace of
// instruction low bytes) into a scoreboard; a monitor closes a record each
// time busy falls and compares. Memory word at address a is 16'hA510 + a.
module tb_instr_sequencer;
    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       run = 1'b0;
    logic       step_mode = 1'b0;
    logic       step_req = 1'b0;
    logic [7:0] prog_len = 8'd0;
    logic       busy, done;
    logic [7:0] instr_count;
    logic       cc_en = 1'b0;
    logic [1:0] cc_step = 2'd3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          tid;
        logic [7:0]  count;
        logic [15:0] instr;
        int          dones;
        int          cyc;
        logic [31:0] trace;
    } exp_t;
    exp_t sb[$];

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .run         (run),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .prog_len    (prog_len),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) bus.imem_data <= 16'hA510 + {8'h00, bus.imem_addr};

    // Control unit model: request retire at the chosen step
    assign bus.clear_counter = cc_en && (bus.current_state == cc_step);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_run(input int tid, input logic [7:0] cnt, input logic [15:0] ins,
                              input int dn, input int cyc, input logic [31:0] tr);
        exp_t e;
        e.tid = tid; e.count = cnt; e.instr = ins; e.dones = dn; e.cyc = cyc; e.trace = tr;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (done === 1'b1) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_addr"},  {24'd0, bus.imem_addr}, 32'd0);
        check({tag, "_instr"}, {16'd0, bus.instruction}, 32'd0);
        check({tag, "_step"},  {30'd0, bus.current_state}, 32'd0);
        check({tag, "_count"}, {24'd0, instr_count}, 32'd0);
    endtask

    // Monitor
    initial begin
        logic        prev_busy;
        logic [15:0] prev_instr;
        int          cyc, dones;
        logic [31:0] trace;
        exp_t        e;
        prev_busy = 1'b0; prev_instr = '0; cyc = 0; dones = 0; trace = '0;
        forever begin
            @(negedge clock);
            if (busy === 1'b1) begin
                if (!prev_busy) begin
                    cyc = 0; dones = 0; trace = '0;
                end
                cyc++;
                if (done === 1'b1) dones++;
                if (bus.instruction !== prev_instr)
                    trace = (trace << 8) | {24'd0, bus.instruction[7:0]};
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_run", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("t%0d_count", e.tid), {24'd0, instr_count}, {24'd0, e.count});
                    check($sformatf("t%0d_instr", e.tid), {16'd0, bus.instruction}, {16'd0, e.instr});
                    check($sformatf("t%0d_dones", e.tid), dones, e.dones);
                    check($sformatf("t%0d_cycles", e.tid), cyc, e.cyc);
                    check($sformatf("t%0d_trace", e.tid), trace, e.trace);
                end
            end
            prev_busy  = (busy === 1'b1);
            prev_instr = bus.instruction;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3 resetn = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // T1: 3 full-length instructions, retire requested at step 11
        @(negedge clock);
        cc_en = 1'b1; cc_step = 2'd3; prog_len = 8'd3;
        expect_run(1, 8'd3, 16'hA512, 1, 19, 32'h0010_1112);
        run = 1'b1;
        wait_done();
        run = 1'b0;
        repeat (3) @(negedge clock);

        // T2: early retire at step 01, 4 cycles per instruction
        cc_step = 2'd1; prog_len = 8'd2;
        expect_run(2, 8'd2, 16'hA511, 1, 9, 32'h0000_1011);
        run = 1'b1;
        wait_done();
        run = 1'b0;
        repeat (3) @(negedge clock);

        // T3: step mode, pause three cycles then release
        cc_en = 1'b0; step_mode = 1'b1; prog_len = 8'd2;
        expect_run(3, 8'd2, 16'hA511, 1, 16, 32'h0000_1011);
        run = 1'b1;
        repeat (9) @(negedge clock);
        check("t3_pause_busy",  {31'd0, busy}, 32'd1);
        check("t3_pause_count", {24'd0, instr_count}, 32'd1);
        check("t3_pause_step",  {30'd0, bus.current_state}, 32'd0);
        step_req = 1'b1;
        @(negedge clock);
        step_req = 1'b0;
        wait_done();
        run = 1'b0; step_mode = 1'b0;
        repeat (3) @(negedge clock);

        // T4: run dropped (and prog_len changed) during EXEC of pc=1
        prog_len = 8'd5;
        expect_run(4, 8'd2, 16'hA511, 0, 12, 32'h0000_1011);
        run = 1'b1;
        repeat (9) @(negedge clock);
        run = 1'b0; prog_len = 8'd2;
        repeat (8) @(negedge clock);

        // T5: reset during EXEC step 10
        prog_len = 8'd3;
        expect_run(5, 8'd0, 16'h0000, 0, 5, 32'h0000_0010);
        run = 1'b1;
        repeat (5) @(negedge clock);
        check("t5_pre_step", {30'd0, bus.current_state}, 32'd2);
        #2 resetn = 1'b0; run = 1'b0;
        #1 check_reset_outputs("t5_reset");
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("t5_idle_after_release", {31'd0, busy}, 32'd0);

        // T6: zero-length program never starts
        prog_len = 8'd0; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check($sformatf("t6_busy_done_%0d", i), {30'd0, busy, done}, 32'd0);
        end
        run = 1'b0;
        @(negedge clock);

        // T7: run=0 wins over step_req in PAUSE
        step_mode = 1'b1; prog_len = 8'd3;
        expect_run(7, 8'd1, 16'hA510, 0, 7, 32'h0000_0010);
        run = 1'b1;
        repeat (7) @(negedge clock);
        run = 1'b0; step_req = 1'b1;
        @(negedge clock);
        step_req = 1'b0; step_mode = 1'b0;
        repeat (4) @(negedge clock);

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width.
REQ-003 Port clock, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port resetn, input, 1: SHALL be the asynchronous, active-low reset.
REQ-005 Port run, input, 1: level; 1 = execute the program, 0 = stop at the next instruction boundary.
REQ-006 Port step_mode, input, 1: 1 = pause after every retired instruction.
REQ-007 Port step_req, input, 1: single-cycle pulse that releases one instruction from PAUSE.
REQ-008 Port prog_len, input, ADDR_W: number of instructions; sampled on leaving IDLE.
REQ-009 Port clear_counter, input, 1: retire request from the control unit.
REQ-010 Port imem_data, input, INSTR_W: synchronous instruction-memory read data, 1-cycle latency.
REQ-011 Port imem_addr, output, ADDR_W: equals pc.
REQ-012 Port instruction, output, INSTR_W: instruction register feeding the control unit.
REQ-013 Port current_state, output, 2: step counter feeding the control unit.
REQ-014 Port busy, output, 1: 1 in every FSM state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse on program completion.
REQ-016 Port instr_count, output, 8: count of retired instructions.

Function
REQ-017 FSM states SHALL be IDLE, F0, F1, EXEC, PAUSE and DONE.
REQ-018 IDLE SHALL go to F0 when run=1 and prog_len!=0, clearing pc and instr_count and latching prog_len; run=1 with prog_len=0 SHALL leave IDLE unchanged with no done pulse.
REQ-019 F0 SHALL present imem_addr=pc for one cycle; F1 SHALL load instruction<=imem_data at its closing edge and go to EXEC.
REQ-020 EXEC SHALL enter with current_state=00 and increment it once per clock (00,01,10,11); current_state SHALL be 00 in all other states.
REQ-021 An instruction SHALL retire at the edge where clear_counter=1 in EXEC; clear_counter=1 in any of 00, 01 or 10 SHALL retire the instruction early.
REQ-022 If clear_counter=0 at current_state=11, the instruction SHALL retire anyway and current_state SHALL wrap to 00.
REQ-023 On retire, pc SHALL increment, instr_count SHALL increment (wrapping 255->0) and the next state SHALL be chosen in this priority: pc+1==latched prog_len -> DONE; run=0 -> IDLE (no done); step_mode=1 -> PAUSE; otherwise F0.
REQ-024 PAUSE SHALL go to F0 on step_req=1, or to IDLE if run=0; run=0 SHALL take priority when both are asserted.
REQ-025 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-026 run, step_mode and prog_len changes during F0, F1 or EXEC SHALL take effect only at the retire boundary.
REQ-027 instruction and instr_count SHALL hold their values in IDLE after completion.
REQ-028 Per-instruction latency SHALL be 2 fetch cycles plus 1-4 EXEC cycles; back-to-back full instructions SHALL take 6 cycles.

Reset
REQ-029 resetn=0 SHALL immediately force state=IDLE, pc=0, imem_addr=0, instruction=16'h0000, current_state=00, busy=0, done=0, instr_count=0 and latched prog_len=0.
REQ-030 A reset asserted mid-instruction SHALL abandon that instruction, with no retire and no done pulse.

Structure
REQ-031 Package instr_seq_pkg SHALL hold the FSM state encoding, the step encodings (00-11), ADDR_W/INSTR_W defaults and the opcode constants shared with control_unit.
REQ-032 The 2-bit step counter SHALL be a sub-module seq_step_counter with inc, clr and an asynchronous active-low reset.

Verification
REQ-033 Reset then prog_len=3, run=1, clear_counter asserted at step 11: imem_addr goes 0,1,2; done pulses once 18 cycles after F0 entry; instr_count=3.
REQ-034 clear_counter=1 at step 01 for the instruction at pc=0: current_state sequence 00,01 then F0 at pc=1; that instruction costs 4 cycles.
REQ-035 step_mode=1, prog_len=2: FSM sits in PAUSE after the first retire until step_req pulses, then completes with done=1.
REQ-036 run dropped to 0 during EXEC of pc=1 with prog_len=5: pc=1 retires, FSM returns to IDLE, done stays 0, instr_count=2.
REQ-037 resetn pulsed low during EXEC step 10: all outputs are at reset values in the same cycle and the FSM is in IDLE after release.
REQ-038 prog_len=0 with run=1: busy stays 0 and done stays 0.
